// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
// Walks one convolution layer through its output-channel groups. Each group runs
// LOAD_BIAS -> LOAD_WEIGHT -> CONV -> DRAIN. After the last group the layer ends in DONE.
// The block generates the address, valid and control strobes for the bias,
// weight and feature-map memories and for the ConvUnit datapath.
//
// Ports
//   clk, rst            : sole clock; synchronous active-high reset
//   start               : layer start pulse (ignored while busy)
//   stall               : holds feature-map streaming during CONV
//   conv_out_valid      : ConvUnit result strobe; advances fm_wr_addr while busy
//   cfg_*               : layer configuration, sampled on an accepted start
//   busy, done          : layer in progress / one-cycle completion pulse
//   current_state       : 0 IDLE, 1 LOAD_BIAS, 2 LOAD_WEIGHT, 3 CONV, 4 DRAIN, 5 DONE
//   state_rst           : one-cycle pulse on the first cycle of every state entered
//   fm_rd_addr/fm_wr_addr, wm_addr_rd, bm_addr_rd : memory addresses
//   bias_out_valid, conv_data_valid, adder_rst, buff_len_rst : datapath strobes
//   buff_len_ctrl, PW_mode, Conv_scale_out : configuration latched at start
//   perf_cycle_cnt, perf_stall_cnt : performance counters
//
// Build option: define SEQ_PERF_CNT_EN to enable the saturating performance counters.
// Without it the perf ports read 0.
module conv_layer_sequencer #(
    parameter int FM_ADDR_W = 13,
    parameter int WM_ADDR_W = 8,
    parameter int BM_ADDR_W = 9,
    parameter int LEN_W     = 9,
    parameter int WT_BEATS  = 9,
    parameter int PIPE_LAT  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 conv_out_valid,
    input  logic                 cfg_pw_mode,
    input  logic [LEN_W-1:0]     cfg_rows,
    input  logic [LEN_W-1:0]     cfg_row_len,
    input  logic [7:0]           cfg_oc_groups,
    input  logic [3:0]           cfg_scale,
    input  logic [FM_ADDR_W-1:0] cfg_fm_rd_base,
    input  logic [FM_ADDR_W-1:0] cfg_fm_wr_base,
    input  logic [WM_ADDR_W-1:0] cfg_wm_base,
    input  logic [BM_ADDR_W-1:0] cfg_bm_base,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           current_state,
    output logic                 state_rst,
    output logic [FM_ADDR_W-1:0] fm_rd_addr,
    output logic [FM_ADDR_W-1:0] fm_wr_addr,
    output logic [WM_ADDR_W-1:0] wm_addr_rd,
    output logic [BM_ADDR_W-1:0] bm_addr_rd,
    output logic                 bias_out_valid,
    output logic                 conv_data_valid,
    output logic                 adder_rst,
    output logic [LEN_W-1:0]     buff_len_ctrl,
    output logic                 buff_len_rst,
    output logic                 PW_mode,
    output logic [3:0]           Conv_scale_out,
    output logic [31:0]          perf_cycle_cnt,
    output logic [31:0]          perf_stall_cnt
);
    localparam int CNT_W = 2 * LEN_W;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD_BIAS   = 3'd1,
        S_LOAD_WEIGHT = 3'd2,
        S_CONV        = 3'd3,
        S_DRAIN       = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t               r_state;
    logic [7:0]           r_g;
    logic [15:0]          r_ph_cnt;      // beat counter shared by LOAD_WEIGHT and DRAIN
    logic [CNT_W-1:0]     r_rd_cnt;      // feature-map reads issued in this group
    logic [CNT_W-1:0]     r_n_reads;
    logic                 r_pw_mode;
    logic [LEN_W-1:0]     r_row_len;
    logic [3:0]           r_scale;
    logic [7:0]           r_oc_groups;
    logic [FM_ADDR_W-1:0] r_fm_rd_base;
    logic [WM_ADDR_W-1:0] r_wm_base;
    logic [BM_ADDR_W-1:0] r_bm_base;
    logic                 r_state_rst;
    logic [FM_ADDR_W-1:0] r_fm_rd_addr;
    logic [FM_ADDR_W-1:0] r_fm_wr_addr;
    logic [WM_ADDR_W-1:0] r_wm_addr;
    logic [BM_ADDR_W-1:0] r_bm_addr;
    logic                 r_bias_valid;
    logic                 r_conv_valid;
    logic                 r_adder_rst;
    logic                 r_buff_len_rst;

    logic [15:0]          w_beats;
    logic [WM_ADDR_W-1:0] w_wm_first;
    logic [7:0]           w_g_next;
    logic                 w_last_group;
    logic                 w_cfg_zero;
    logic                 w_reads_left;
    logic [FM_ADDR_W-1:0] w_rd_next_addr;

    assign w_beats        = r_pw_mode ? 16'd1 : 16'(WT_BEATS);
    assign w_wm_first     = r_wm_base + WM_ADDR_W'(16'(r_g) * w_beats);
    assign w_g_next       = r_g + 8'd1;
    assign w_last_group   = ({1'b0, r_g} + 9'd1) >= {1'b0, r_oc_groups};
    assign w_cfg_zero     = (cfg_rows == '0) || (cfg_row_len == '0) || (cfg_oc_groups == '0);
    assign w_reads_left   = (r_rd_cnt != r_n_reads);
    // The first read of a group (including one delayed by stall at CONV entry) sits at the base.
    assign w_rd_next_addr = (r_rd_cnt == '0) ? r_fm_rd_base : r_fm_rd_addr + FM_ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_g            <= '0;
            r_ph_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_n_reads      <= '0;
            r_pw_mode      <= 1'b0;
            r_row_len      <= '0;
            r_scale        <= '0;
            r_oc_groups    <= '0;
            r_fm_rd_base   <= '0;
            r_wm_base      <= '0;
            r_bm_base      <= '0;
            r_state_rst    <= 1'b0;
            r_fm_rd_addr   <= '0;
            r_fm_wr_addr   <= '0;
            r_wm_addr      <= '0;
            r_bm_addr      <= '0;
            r_bias_valid   <= 1'b0;
            r_conv_valid   <= 1'b0;
            r_adder_rst    <= 1'b0;
            r_buff_len_rst <= 1'b0;
        end else begin
            // Strobes and addresses fall back to 0 unless the branch below drives them.
            r_state_rst    <= 1'b0;
            r_bias_valid   <= 1'b0;
            r_conv_valid   <= 1'b0;
            r_adder_rst    <= 1'b0;
            r_buff_len_rst <= 1'b0;
            r_fm_rd_addr   <= '0;
            r_wm_addr      <= '0;
            r_bm_addr      <= '0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pw_mode    <= cfg_pw_mode;
                        r_row_len    <= cfg_row_len;
                        r_scale      <= cfg_scale;
                        r_oc_groups  <= cfg_oc_groups;
                        r_fm_rd_base <= cfg_fm_rd_base;
                        r_wm_base    <= cfg_wm_base;
                        r_bm_base    <= cfg_bm_base;
                        r_n_reads    <= CNT_W'(cfg_rows) * CNT_W'(cfg_row_len);
                        r_g          <= '0;
                        r_rd_cnt     <= '0;
                        r_ph_cnt     <= '0;
                        r_state_rst  <= 1'b1;
                        if (w_cfg_zero) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state      <= S_LOAD_BIAS;
                            r_bias_valid <= 1'b1;
                            r_bm_addr    <= cfg_bm_base;
                        end
                    end
                end
                S_LOAD_BIAS: begin
                    r_state     <= S_LOAD_WEIGHT;
                    r_state_rst <= 1'b1;
                    r_wm_addr   <= w_wm_first;
                    r_ph_cnt    <= '0;
                end
                S_LOAD_WEIGHT: begin
                    if (r_ph_cnt == w_beats - 16'd1) begin
                        // Entering CONV: the first read is issued now unless stalled.
                        r_state        <= S_CONV;
                        r_state_rst    <= 1'b1;
                        r_adder_rst    <= 1'b1;
                        r_buff_len_rst <= 1'b1;
                        r_rd_cnt       <= stall ? CNT_W'(0) : CNT_W'(1);
                        r_conv_valid   <= ~stall;
                        r_fm_rd_addr   <= r_fm_rd_base;
                    end else begin
                        r_ph_cnt  <= r_ph_cnt + 16'd1;
                        r_wm_addr <= r_wm_addr + WM_ADDR_W'(1);
                    end
                end
                S_CONV: begin
                    if (!w_reads_left) begin
                        r_state     <= S_DRAIN;
                        r_state_rst <= 1'b1;
                        r_ph_cnt    <= '0;
                        r_rd_cnt    <= '0;
                    end else if (!stall) begin
                        r_conv_valid <= 1'b1;
                        r_fm_rd_addr <= w_rd_next_addr;
                        r_rd_cnt     <= r_rd_cnt + CNT_W'(1);
                    end else begin
                        r_fm_rd_addr <= r_fm_rd_addr;
                    end
                end
                S_DRAIN: begin
                    if (r_ph_cnt == 16'(PIPE_LAT - 1)) begin
                        r_state_rst <= 1'b1;
                        if (w_last_group) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state      <= S_LOAD_BIAS;
                            r_g          <= w_g_next;
                            r_bias_valid <= 1'b1;
                            r_bm_addr    <= r_bm_base + BM_ADDR_W'(w_g_next);
                        end
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_state_rst <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Result write pointer: only ConvUnit strobes seen during a layer count.
            if (r_state == S_IDLE) begin
                if (start) r_fm_wr_addr <= cfg_fm_wr_base;
            end else if (conv_out_valid) begin
                r_fm_wr_addr <= r_fm_wr_addr + FM_ADDR_W'(1);
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_perf_cycle;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycle <= '0;
            r_perf_stall <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_perf_cycle <= '0;
                r_perf_stall <= '0;
            end
        end else begin
            if (r_perf_cycle != '1) r_perf_cycle <= r_perf_cycle + 32'd1;
            if (r_state == S_CONV && stall && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_cycle_cnt = r_perf_cycle;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_cycle_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign current_state   = r_state;
    assign state_rst       = r_state_rst;
    assign fm_rd_addr      = r_fm_rd_addr;
    assign fm_wr_addr      = r_fm_wr_addr;
    assign wm_addr_rd      = r_wm_addr;
    assign bm_addr_rd      = r_bm_addr;
    assign bias_out_valid  = r_bias_valid;
    assign conv_data_valid = r_conv_valid;
    assign adder_rst       = r_adder_rst;
    assign buff_len_ctrl   = r_row_len;
    assign buff_len_rst    = r_buff_len_rst;
    assign PW_mode         = r_pw_mode;
    assign Conv_scale_out  = r_scale;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed testbench for conv_layer_sequencer. Expected values are hand-derived
// cycle counts and address sequences. Cycle 1 is the cycle right after the
// start edge. Prints one line per layer run.
module tb_conv_layer_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic        conv_out_valid;
    logic        cfg_pw_mode;
    logic [8:0]  cfg_rows;
    logic [8:0]  cfg_row_len;
    logic [7:0]  cfg_oc_groups;
    logic [3:0]  cfg_scale;
    logic [12:0] cfg_fm_rd_base;
    logic [12:0] cfg_fm_wr_base;
    logic [7:0]  cfg_wm_base;
    logic [8:0]  cfg_bm_base;
    logic        busy;
    logic        done;
    logic [2:0]  current_state;
    logic        state_rst;
    logic [12:0] fm_rd_addr;
    logic [12:0] fm_wr_addr;
    logic [7:0]  wm_addr_rd;
    logic [8:0]  bm_addr_rd;
    logic        bias_out_valid;
    logic        conv_data_valid;
    logic        adder_rst;
    logic [8:0]  buff_len_ctrl;
    logic        buff_len_rst;
    logic        PW_mode;
    logic [3:0]  Conv_scale_out;
    logic [31:0] perf_cycle_cnt;
    logic [31:0] perf_stall_cnt;

    conv_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .conv_out_valid(conv_out_valid), .cfg_pw_mode(cfg_pw_mode),
        .cfg_rows(cfg_rows), .cfg_row_len(cfg_row_len),
        .cfg_oc_groups(cfg_oc_groups), .cfg_scale(cfg_scale),
        .cfg_fm_rd_base(cfg_fm_rd_base), .cfg_fm_wr_base(cfg_fm_wr_base),
        .cfg_wm_base(cfg_wm_base), .cfg_bm_base(cfg_bm_base),
        .busy(busy), .done(done), .current_state(current_state),
        .state_rst(state_rst), .fm_rd_addr(fm_rd_addr), .fm_wr_addr(fm_wr_addr),
        .wm_addr_rd(wm_addr_rd), .bm_addr_rd(bm_addr_rd),
        .bias_out_valid(bias_out_valid), .conv_data_valid(conv_data_valid),
        .adder_rst(adder_rst), .buff_len_ctrl(buff_len_ctrl),
        .buff_len_rst(buff_len_rst), .PW_mode(PW_mode),
        .Conv_scale_out(Conv_scale_out), .perf_cycle_cnt(perf_cycle_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Results gathered by run_layer
    int          done_cyc, n_done, n_srst, n_adder, n_blr, n_inval, conv_c;
    int          n_st[6];
    logic [31:0] addr_c5, wr_at_done, perf_cyc_end, perf_stall_end;
    logic [31:0] rd_q[$];
    logic [31:0] wm_q[$];
    logic [31:0] bm_q[$];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic pw, input int rows, input int len, input int grp,
                           input int fm_rd, input int fm_wr, input int wm, input int bm,
                           input int scale);
        cfg_pw_mode    = pw;
        cfg_rows       = 9'(rows);
        cfg_row_len    = 9'(len);
        cfg_oc_groups  = 8'(grp);
        cfg_fm_rd_base = 13'(fm_rd);
        cfg_fm_wr_base = 13'(fm_wr);
        cfg_wm_base    = 8'(wm);
        cfg_bm_base    = 9'(bm);
        cfg_scale      = 4'(scale);
    endtask

    // Pulses start, then observes every cycle until IDLE. A stall window is
    // applied while CONV cycles s_at .. s_at+s_len-1 are observed. conv_out_valid
    // is driven on every DRAIN cycle.
    task automatic run_layer(input string name, input int s_at, input int s_len);
        int cyc;
        bit fin;
        done_cyc = 0; n_done = 0; n_srst = 0; n_adder = 0; n_blr = 0;
        n_inval = 0; conv_c = 0; addr_c5 = 0; wr_at_done = 0;
        for (int i = 0; i < 6; i++) n_st[i] = 0;
        rd_q.delete(); wm_q.delete(); bm_q.delete();
        cyc = 0; fin = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!fin && cyc < 300) begin
            cyc++;
            n_st[current_state]++;
            if (done) begin
                n_done++;
                done_cyc   = cyc;
                wr_at_done = 32'(fm_wr_addr);
            end
            if (conv_data_valid) rd_q.push_back(32'(fm_rd_addr));
            if (current_state == 3'd3) begin
                conv_c++;
                if (!conv_data_valid) n_inval++;
                if (conv_c == 5) addr_c5 = 32'(fm_rd_addr);
            end
            if (current_state == 3'd2) wm_q.push_back(32'(wm_addr_rd));
            if (bias_out_valid) bm_q.push_back(32'(bm_addr_rd));
            if (state_rst && current_state >= 3'd1 && current_state <= 3'd4) n_srst++;
            if (adder_rst) n_adder++;
            if (buff_len_rst) n_blr++;
            if (current_state == 3'd0) begin
                fin = 1;
            end else begin
                stall = (current_state == 3'd3) && (conv_c >= s_at) && (conv_c < s_at + s_len);
                conv_out_valid = (current_state == 3'd4);
                step();
            end
        end
        stall = 1'b0;
        conv_out_valid = 1'b0;
        perf_cyc_end   = perf_cycle_cnt;
        perf_stall_end = perf_stall_cnt;
        chk_val({name, "_ends"}, 32'(fin), 32'd1);
        $display("layer %s: done_cyc=%0d reads=%0d conv_cycles=%0d", name, done_cyc,
                 rd_q.size(), n_st[3]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; conv_out_valid = 1'b0;
        set_cfg(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk_val("rst_state", 32'(current_state), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_fm_rd", 32'(fm_rd_addr), 32'd0);
        chk_val("rst_perf", perf_cycle_cnt, 32'd0);
        rst = 1'b0;
        step();

        // 3x3, rows=2 row_len=4, one group
        set_cfg(1'b0, 2, 4, 1, 100, 200, 20, 0, 5);
        run_layer("t1", 0, 0);
        chk_val("t1_done_cyc", 32'(done_cyc), 32'd27);
        chk_val("t1_n_done", 32'(n_done), 32'd1);
        chk_val("t1_lb", 32'(n_st[1]), 32'd1);
        chk_val("t1_lw", 32'(n_st[2]), 32'd9);
        chk_val("t1_conv", 32'(n_st[3]), 32'd8);
        chk_val("t1_drain", 32'(n_st[4]), 32'd8);
        chk_val("t1_nrd", 32'(rd_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < rd_q.size(); i++)
            chk_val("t1_rd", rd_q[i], 32'(100 + i));
        chk_val("t1_nwm", 32'(wm_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < wm_q.size(); i++)
            chk_val("t1_wm", wm_q[i], 32'(20 + i));
        chk_val("t1_adder_rst", 32'(n_adder), 32'd1);
        chk_val("t1_blr", 32'(n_blr), 32'd1);
        chk_val("t1_fm_wr", wr_at_done, 32'd208);
        chk_val("t1_scale", 32'(Conv_scale_out), 32'd5);
        chk_val("t1_buff_len", 32'(buff_len_ctrl), 32'd4);
`ifdef SEQ_PERF_CNT_EN
        chk_val("t1_perf_cyc", perf_cyc_end, 32'd27);
`else
        chk_val("t1_perf_cyc", perf_cyc_end, 32'd0);
`endif
        // conv_out_valid in IDLE must not move the write pointer
        conv_out_valid = 1'b1;
        step(); step(); step();
        conv_out_valid = 1'b0;
        chk_val("idle_wr_hold", 32'(fm_wr_addr), 32'd208);

        // Pointwise, 3 groups, rows=1 row_len=2
        set_cfg(1'b1, 1, 2, 3, 50, 0, 10, 5, 2);
        run_layer("t2", 0, 0);
        chk_val("t2_done_cyc", 32'(done_cyc), 32'd37);
        chk_val("t2_nwm", 32'(wm_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < wm_q.size(); i++)
            chk_val("t2_wm", wm_q[i], 32'(10 + i));
        chk_val("t2_nbm", 32'(bm_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < bm_q.size(); i++)
            chk_val("t2_bm", bm_q[i], 32'(5 + i));
        chk_val("t2_nrd", 32'(rd_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < rd_q.size(); i++)
            chk_val("t2_rd", rd_q[i], 32'(50 + (i % 2)));
        chk_val("t2_state_rst", 32'(n_srst), 32'd12);
        chk_val("t2_adder_rst", 32'(n_adder), 32'd3);
        chk_val("t2_pw_mode", 32'(PW_mode), 32'd1);

        // Stall for 3 cycles mid-CONV
        set_cfg(1'b0, 2, 4, 1, 300, 0, 0, 0, 1);
        run_layer("t3", 3, 3);
        chk_val("t3_done_cyc", 32'(done_cyc), 32'd30);
        chk_val("t3_conv", 32'(n_st[3]), 32'd11);
        chk_val("t3_inval", 32'(n_inval), 32'd3);
        chk_val("t3_hold_addr", addr_c5, 32'd302);
        chk_val("t3_nrd", 32'(rd_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < rd_q.size(); i++)
            chk_val("t3_rd", rd_q[i], 32'(300 + i));
`ifdef SEQ_PERF_CNT_EN
        chk_val("t3_perf_stall", perf_stall_end, 32'd3);
        chk_val("t3_perf_cyc", perf_cyc_end, 32'd30);
`else
        chk_val("t3_perf_stall", perf_stall_end, 32'd0);
        chk_val("t3_perf_cyc", perf_cyc_end, 32'd0);
`endif

        // Feature-map read address wrap
        set_cfg(1'b1, 1, 4, 1, 8190, 0, 0, 0, 0);
        run_layer("t4", 0, 0);
        chk_val("t4_nrd", 32'(rd_q.size()), 32'd4);
        if (rd_q.size() == 4) begin
            chk_val("t4_rd0", rd_q[0], 32'd8190);
            chk_val("t4_rd1", rd_q[1], 32'd8191);
            chk_val("t4_rd2", rd_q[2], 32'd0);
            chk_val("t4_rd3", rd_q[3], 32'd1);
        end

        // Zero rows: straight to DONE
        set_cfg(1'b0, 0, 4, 1, 0, 0, 0, 0, 0);
        run_layer("t5", 0, 0);
        chk_val("t5_done_cyc", 32'(done_cyc), 32'd1);
        chk_val("t5_n_done", 32'(n_done), 32'd1);
        chk_val("t5_nrd", 32'(rd_q.size()), 32'd0);
        chk_val("t5_lb", 32'(n_st[1]), 32'd0);

        // Start while busy is ignored; reset mid-CONV; start right after reset
        set_cfg(1'b0, 2, 4, 1, 10, 60, 0, 0, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30 && current_state != 3'd3; i++) step();
        chk_val("t6_in_conv", 32'(current_state), 32'd3);
        set_cfg(1'b1, 1, 1, 1, 0, 0, 0, 0, 9);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_val("t6_busy_start_state", 32'(current_state), 32'd3);
        chk_val("t6_busy_start_scale", 32'(Conv_scale_out), 32'd5);
        rst = 1'b1;
        start = 1'b1;
        step();
        chk_val("t6_rst_state", 32'(current_state), 32'd0);
        chk_val("t6_rst_busy", 32'(busy), 32'd0);
        chk_val("t6_rst_valid", 32'(conv_data_valid), 32'd0);
        chk_val("t6_rst_fm_rd", 32'(fm_rd_addr), 32'd0);
        chk_val("t6_rst_fm_wr", 32'(fm_wr_addr), 32'd0);
        chk_val("t6_rst_scale", 32'(Conv_scale_out), 32'd0);
        chk_val("t6_rst_blen", 32'(buff_len_ctrl), 32'd0);
        chk_val("t6_rst_srst", 32'(state_rst), 32'd0);
        rst = 1'b0;
        step();
        start = 1'b0;
        chk_val("t6_restart_state", 32'(current_state), 32'd1);
        chk_val("t6_restart_scale", 32'(Conv_scale_out), 32'd9);
        for (int i = 0; i < 100 && current_state != 3'd0; i++) step();
        chk_val("t6_final_idle", 32'(current_state), 32'd0);
        $display("layer t6: reset mid-CONV and restart finished");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameters FM_ADDR_W=13 (feature-map address width), WM_ADDR_W=8 (weight read address width), BM_ADDR_W=9 (bias read address width), LEN_W=9 (row-length/count width), WT_BEATS=9 (weight beats per group, 3x3 mode), PIPE_LAT=8 (ConvUnit drain cycles).
REQ-002 SHALL have ports: clk in 1 (sole clock); rst in 1 (synchronous, active-high reset).
REQ-003 SHALL have ports: start in 1 (layer start pulse); stall in 1 (hold streaming); conv_out_valid in 1 (ConvUnit output valid).
REQ-004 SHALL have config inputs, sampled on accepted start: cfg_pw_mode 1; cfg_rows LEN_W; cfg_row_len LEN_W; cfg_oc_groups 8; cfg_scale 4; cfg_fm_rd_base FM_ADDR_W; cfg_fm_wr_base FM_ADDR_W; cfg_wm_base WM_ADDR_W; cfg_bm_base BM_ADDR_W.
REQ-005 SHALL have outputs: busy 1; done 1 (pulse); current_state 3; state_rst 1; fm_rd_addr FM_ADDR_W; fm_wr_addr FM_ADDR_W; wm_addr_rd WM_ADDR_W; bm_addr_rd BM_ADDR_W; bias_out_valid 1; conv_data_valid 1; adder_rst 1; buff_len_ctrl LEN_W; buff_len_rst 1; PW_mode 1; Conv_scale_out 4; perf_cycle_cnt 32; perf_stall_cnt 32.

Function
REQ-006 SHALL implement states IDLE=0, LOAD_BIAS=1, LOAD_WEIGHT=2, CONV=3, DRAIN=4, DONE=5, driven on current_state.
REQ-007 IDLE: start with any of cfg_rows, cfg_row_len, cfg_oc_groups zero SHALL go to DONE; otherwise SHALL go to LOAD_BIAS the next cycle, group counter g=0.
REQ-008 start while busy SHALL be ignored; busy SHALL be 1 in every state except IDLE.
REQ-009 LOAD_BIAS: SHALL last 1 cycle with bias_out_valid=1, bm_addr_rd=cfg_bm_base+g (modulo 2^BM_ADDR_W).
REQ-010 LOAD_WEIGHT: SHALL last B cycles (B=1 if cfg_pw_mode else WT_BEATS); wm_addr_rd SHALL step by 1 per cycle from cfg_wm_base+g*B, wrapping modulo 2^WM_ADDR_W.
REQ-011 CONV: SHALL issue N=cfg_rows*cfg_row_len reads; per non-stalled cycle conv_data_valid=1 and fm_rd_addr steps by 1 from cfg_fm_rd_base (wrapping modulo 2^FM_ADDR_W); stall=1 SHALL hold fm_rd_addr and force conv_data_valid=0.
REQ-012 fm_rd_addr SHALL restart at cfg_fm_rd_base for every group.
REQ-013 adder_rst and buff_len_rst SHALL pulse 1 cycle on the first CONV cycle of each group.
REQ-014 DRAIN: SHALL last exactly PIPE_LAT cycles, then go to LOAD_BIAS with g+1 if g+1<cfg_oc_groups, else DONE.
REQ-015 DONE: SHALL last 1 cycle with done=1, then go to IDLE.
REQ-016 state_rst SHALL pulse 1 cycle on the first cycle of every state entered, including re-entry of LOAD_BIAS.
REQ-017 fm_wr_addr SHALL load cfg_fm_wr_base on accepted start and increment by 1 (wrapping) per conv_out_valid=1 cycle in any busy state; conv_out_valid in IDLE SHALL be ignored.
REQ-018 buff_len_ctrl, PW_mode, Conv_scale_out SHALL hold the values latched at start until the next accepted start.
REQ-019 Address/valid outputs SHALL be registered; 0 in states where not driven by REQ-009..011.

Reset
REQ-020 rst=1 at any clock edge SHALL force IDLE and all outputs to 0, including mid-layer; rst has priority over start.
REQ-021 First cycle after rst deassert SHALL accept start.

Configuration
REQ-022 With SEQ_PERF_CNT_EN defined: perf_cycle_cnt SHALL count busy cycles and perf_stall_cnt SHALL count CONV cycles with stall=1, both cleared on accepted start and saturating at 2^32-1.
REQ-023 Without SEQ_PERF_CNT_EN: both perf ports SHALL remain present and tied to 0; no counter logic.

Verification
REQ-024 3x3: rows=2, row_len=4, groups=1, no stall -> LOAD_BIAS 1 + LOAD_WEIGHT 9 + CONV 8 + DRAIN 8 cycles, done 27 cycles after start edge, fm_rd_addr base..base+7.
REQ-025 PW, groups=3, wm_base=10, bm_base=5 -> wm_addr_rd 10,11,12; bm_addr_rd 5,6,7; fm_rd_addr restarts at base thrice; state_rst 12 pulses.
REQ-026 Stall 3 cycles mid-CONV -> fm_rd_addr held, conv_data_valid 0 for 3 cycles, completion 3 cycles later; perf_stall_cnt=3 with macro, 0 without.
REQ-027 fm_rd_base=8190, N=4 -> fm_rd_addr 8190, 8191, 0, 1.
REQ-028 cfg_rows=0 -> DONE next cycle, done pulse, conv_data_valid never 1; start while busy and rst mid-CONV -> start ignored, IDLE with all outputs 0 after rst edge.
